mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single data-memory port between instruction fetch (IFU) and load/store (LSU). It sits between the fetch and memory-access stages and the `memory` block, replacing their direct connections once the core moves to a split IF/ID pipeline. It keeps one transaction outstanding, uses a valid/ready handshake on every request channel, and routes each response back to the requester that issued it.

## Interface
- `ADDR_WIDTH`, 64, request address width
- `DATA_WIDTH`, 64, read/write data width
- `clk`  in  1  clock; one clock domain; all state updates on posedge
- `rst`  in  1  reset; asynchronous, active-high
- `ifu_req_valid`  in  1  IFU read request
- `ifu_req_ready`  out  1  IFU request accepted this cycle
- `ifu_addr`  in  ADDR_WIDTH  fetch address
- `ifu_resp_valid`  out  1  IFU read data valid, one-cycle pulse
- `ifu_resp_data`  out  DATA_WIDTH  fetch data
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_ready`  out  1  LSU request accepted this cycle
- `lsu_addr`  in  ADDR_WIDTH  load/store address
- `lsu_wen`  in  1  1 = store, 0 = load
- `lsu_wdata`  in  DATA_WIDTH  store data
- `lsu_wmask`  in  8  byte write mask
- `lsu_resp_valid`  out  1  load data or store acknowledge, one-cycle pulse
- `lsu_resp_data`  out  DATA_WIDTH  load data
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  ADDR_WIDTH/1/DATA_WIDTH/8  latched request fields
- `mem_resp_valid`  in  1  memory response
- `mem_resp_data`  in  DATA_WIDTH  memory read data

## Operation
- FSM has three states:
  - IDLE: grant is combinational. The granted requester sees `*_req_ready`=1. On valid&ready, latch addr/wen/wdata/wmask and the owner (IFU forces wen=0, wmask=0), then go to REQ. With no valid request, stay in IDLE.
  - REQ: `mem_req_valid`=1 with the latched fields, held stable. On `mem_req_ready`=1, go to RESP.
  - RESP: wait for `mem_resp_valid`. When it arrives, pulse the owner's `*_resp_valid` (combinational pass-through) with `*_resp_data`=`mem_resp_data`, then go to IDLE.
- Both `*_req_ready` are 0 outside IDLE. The non-owner's `*_resp_valid` is always 0.
- `mem_resp_valid` in IDLE or REQ is ignored. It changes no state and produces no output pulse.
- Store responses: `lsu_resp_valid` pulses as an acknowledge, and `lsu_resp_data` forwards `mem_resp_data` unchanged.
- Grant when both requesters are valid follows the policy set in Configuration.
- A requester keeps valid high and its fields stable until it sees ready.

## Timing
- Reset values: state IDLE, every output 0, latched fields 0, owner = IFU, last-grant pointer = LSU.
- Accept at cycle N; `mem_req_valid`=1 at N+1.
- With `mem_req_ready`=1 at N+1, the state is RESP at N+2.
- With `mem_resp_valid` at N+2, the owner's resp pulse is at N+2 and the next accept is possible at N+3.
- Minimum spacing is 3 cycles per transaction. Each cycle of memory backpressure adds one cycle of latency.
- Asserting `rst` in any state forces all outputs to 0 immediately and drops the in-flight transaction. `memory` must be reset in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin grant on a tie.
  - Grant goes to the requester that is not the last-grant pointer.
  - The pointer updates on every accept.
  - Reset pointer = LSU, so the first tie goes to IFU.
- `MEM_ARB_RR_EN` undefined: fixed priority, LSU wins every tie. The pointer register is not instantiated. IFU can be starved while LSU keeps valid high.

## Test plan
- IFU alone reads `ifu_addr`=0x80000000, `mem_req_ready`=1, memory returns 0x00100073 one cycle later:
  - `mem_addr`=0x80000000 and `mem_wen`=0 at N+1.
  - `ifu_resp_valid`=1 with data 0x00100073 at N+2 only.
  - `lsu_resp_valid` stays 0.
- Tie, macro undefined. LSU store (0x80001000, wdata 0x1122334455667788, wmask 0xFF) and IFU read are both valid:
  - The LSU store is issued first with `mem_wen`=1 and `mem_wmask`=0xFF.
  - IFU is accepted at N+3.
- Both requesters continuously valid for 4 transactions:
  - With `MEM_ARB_RR_EN`, grants are IFU, LSU, IFU, LSU.
  - Without it, grants are LSU ×4 and `ifu_req_ready` never rises.
- `mem_req_ready` held 0 for 5 cycles in REQ:
  - `mem_req_valid` stays 1 with `mem_addr` unchanged.
  - Both `*_req_ready` stay 0.
  - The transaction completes 5 cycles later than nominal.
- `rst` pulsed while in RESP:
  - Outputs are 0 in the same cycle.
  - After release, a stray `mem_resp_valid` produces no resp pulse.
  - The next IFU request is accepted normally.
- `mem_resp_valid` asserted in IDLE and in REQ: no `*_resp_valid` pulse and no state change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory channels around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_addr;
    logic                  ifu_resp_valid;
    logic [DATA_WIDTH-1:0] ifu_resp_data;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic                  lsu_wen;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic [7:0]            lsu_wmask;
    logic                  lsu_resp_valid;
    logic [DATA_WIDTH-1:0] lsu_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [7:0]            mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter for the single data-memory port, one transaction outstanding.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise LSU wins every tie.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state, state_nxt;
    logic                  owner_lsu;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            wmask_q;
    logic                  grant_lsu, grant_ifu, accept;

`ifdef MEM_ARB_RR_EN
    logic last_lsu;

    // Tie goes to whoever was not granted last; reset value favours IFU first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_lsu <= 1'b1;
        else if (accept) last_lsu <= grant_lsu;
    end

    assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
`else
    assign grant_lsu = bus.lsu_req_valid;
`endif
    assign grant_ifu = bus.ifu_req_valid && !grant_lsu;
    assign accept    = (state == IDLE) && !rst && (grant_ifu || grant_lsu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so outputs drop in the same cycle reset rises.
                bus.ifu_req_ready = grant_ifu && !rst;
                bus.lsu_req_ready = grant_lsu && !rst;
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_nxt = RESP;
            end
            RESP: begin
                if (bus.mem_resp_valid) begin
                    bus.ifu_resp_valid = !owner_lsu;
                    bus.lsu_resp_valid = owner_lsu;
                    state_nxt          = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IFU requests are always reads: wen, wdata and wmask latch as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_lsu <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else if (accept) begin
            owner_lsu <= grant_lsu;
            addr_q    <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            wen_q     <= grant_lsu && bus.lsu_wen;
            wdata_q   <= grant_lsu ? bus.lsu_wdata : '0;
            wmask_q   <= grant_lsu ? bus.lsu_wmask : '0;
        end
    end

    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
    assign bus.ifu_resp_data = bus.ifu_resp_valid ? bus.mem_resp_data : '0;
    assign bus.lsu_resp_data = bus.lsu_resp_valid ? bus.mem_resp_data : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle table, directed corner sequences, and a
// randomized phase scored against a transaction-level model.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [63:0] IFU_ADDR = 64'h8000_0000;
    localparam logic [63:0] LSU_ADDR = 64'h8000_1000;
    localparam logic [63:0] WDATA    = 64'h1122_3344_5566_7788;
    localparam logic [63:0] RDATA    = 64'h0010_0073;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();
    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       ifu_v, lsu_v, mrdy, mrsp;
        logic [4:0] exp;  // {ifu_rdy, lsu_rdy, mem_req_valid, ifu_resp, lsu_resp}
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [4:0] outs();
        return {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid,
                bus.ifu_resp_valid, bus.lsu_resp_valid};
    endfunction

    function automatic logic [136:0] fields();
        return {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
    endfunction

    function automatic vec_t mk(input logic iv, lv, rd, rs, input logic [4:0] e);
        vec_t v;
        v.ifu_v = iv; v.lsu_v = lv; v.mrdy = rd; v.mrsp = rs; v.exp = e;
        return v;
    endfunction

    // Entered at posedge+1; applies inputs, checks at negedge, exits at next posedge+1.
    task automatic run_cycle(input string name, input logic iv, lv, rd, rs, input logic [4:0] e);
        bus.ifu_req_valid  = iv;
        bus.lsu_req_valid  = lv;
        bus.mem_req_ready  = rd;
        bus.mem_resp_valid = rs;
        @(negedge clk);
        check(name, outs(), e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1; bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        check("reset_ctl", outs(), 5'b0);
        check("reset_fields", fields(), 137'b0);
        check("reset_data", {bus.ifu_resp_data, bus.lsu_resp_data}, 128'b0);
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0; bus.mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Reference policy: winner among currently valid requesters.
    function automatic bit pick_lsu(input bit iv, lv, last_lsu);
        if (iv && lv) return RR ? !last_lsu : 1'b1;
        return lv;
    endfunction

    initial begin
        bit grants[$];
        bit ifu_seen, store_pending;
        bit busy, macc, own, last, free, wl, e_ir, e_lr, e_mq, e_rsp;
        logic [136:0] txn;

        rst = 1'b1;
        bus.ifu_req_valid = 0; bus.lsu_req_valid = 0; bus.mem_req_ready = 0;
        bus.mem_resp_valid = 0;
        bus.ifu_addr = IFU_ADDR; bus.lsu_addr = LSU_ADDR; bus.lsu_wen = 1'b1;
        bus.lsu_wdata = WDATA; bus.lsu_wmask = 8'hFF; bus.mem_resp_data = RDATA;
        @(posedge clk); #1;
        do_reset();

        // Cycle-by-cycle table starting from IDLE right after reset.
        tbl[0]  = mk(0, 0, 0, 0, 5'b00000);
        tbl[1]  = mk(1, 0, 0, 0, 5'b10000);
        tbl[2]  = mk(0, 0, 1, 0, 5'b00100);
        tbl[3]  = mk(0, 0, 0, 1, 5'b00010);
        tbl[4]  = mk(0, 0, 0, 0, 5'b00000);
        tbl[5]  = mk(0, 0, 0, 1, 5'b00000);
        tbl[6]  = mk(0, 1, 0, 0, 5'b01000);
        tbl[7]  = mk(0, 0, 0, 1, 5'b00100);
        tbl[8]  = mk(0, 0, 1, 0, 5'b00100);
        tbl[9]  = mk(0, 0, 0, 0, 5'b00000);
        tbl[10] = mk(0, 0, 0, 1, 5'b00001);
        tbl[11] = mk(1, 1, 0, 0, {RR, !RR, 3'b000});
        tbl[12] = mk(!RR, RR, 1, 0, 5'b00100);
        tbl[13] = mk(!RR, RR, 0, 1, {3'b000, RR, !RR});
        tbl[14] = mk(!RR, RR, 0, 0, {!RR, RR, 3'b000});
        tbl[15] = mk(0, 0, 1, 0, 5'b00100);
        tbl[16] = mk(0, 0, 0, 1, {3'b000, !RR, RR});
        tbl[17] = mk(0, 0, 0, 0, 5'b00000);
        for (int i = 0; i < 18; i++)
            run_cycle($sformatf("table_row%0d", i), tbl[i].ifu_v, tbl[i].lsu_v,
                      tbl[i].mrdy, tbl[i].mrsp, tbl[i].exp);

        // IFU read: address/wen at N+1, data pulse at N+2 only.
        do_reset();
        run_cycle("ifu_accept", 1, 0, 0, 0, 5'b10000);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check("ifu_mem_req", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen}, {1'b1, IFU_ADDR, 1'b0});
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        check("ifu_resp", {bus.ifu_resp_valid, bus.ifu_resp_data, bus.lsu_resp_valid}, {1'b1, RDATA, 1'b0});
        @(posedge clk); #1;
        run_cycle("ifu_resp_once", 0, 0, 0, 1, 5'b00000);

        // Both continuously valid for four grants.
        do_reset();
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; bus.mem_req_ready = 1; bus.mem_resp_valid = 1;
        ifu_seen = 0; store_pending = 0;
        for (int c = 0; c < 14 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (store_pending)
                check("store_fields", fields(), {LSU_ADDR, 1'b1, WDATA, 8'hFF});
            store_pending = bus.lsu_req_ready;
            if (bus.ifu_req_ready) begin ifu_seen = 1; grants.push_back(1'b0); end
            if (bus.lsu_req_ready) grants.push_back(1'b1);
            @(posedge clk); #1;
        end
        check("grant_count", grants.size(), 4);
        for (int g = 0; g < 4 && g < grants.size(); g++)
            check($sformatf("grant%0d", g), grants[g], RR ? g[0] : 1'b1);
        if (!RR) check("ifu_starved", ifu_seen, 1'b0);

        // Five cycles of memory backpressure while LSU waits.
        do_reset();
        run_cycle("bp_accept", 1, 0, 0, 0, 5'b10000);
        for (int k = 0; k < 5; k++) begin
            run_cycle($sformatf("bp_stall%0d", k), 0, 1, 0, 1, 5'b00100);
            check($sformatf("bp_addr%0d", k), bus.mem_addr, IFU_ADDR);
        end
        run_cycle("bp_go", 0, 1, 1, 0, 5'b00100);
        run_cycle("bp_resp", 0, 1, 0, 1, 5'b00010);
        run_cycle("bp_lsu_accept", 0, 1, 0, 0, 5'b01000);

        // Reset while a transaction sits in RESP.
        do_reset();
        run_cycle("rr_accept", 1, 0, 0, 0, 5'b10000);
        run_cycle("rr_req", 0, 0, 1, 0, 5'b00100);
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; bus.mem_resp_valid = 1;
        rst = 1'b1;
        #1;
        check("rst_resp_ctl", outs(), 5'b0);
        check("rst_resp_fields", fields(), 137'b0);
        @(posedge clk); #1;
        bus.ifu_req_valid = 0; bus.lsu_req_valid = 0; bus.mem_resp_valid = 0;
        rst = 1'b0;
        run_cycle("rst_stray_resp", 0, 0, 0, 1, 5'b00000);
        run_cycle("rst_next_accept", 1, 0, 0, 0, 5'b10000);
        run_cycle("rst_next_req", 0, 0, 1, 0, 5'b00100);
        run_cycle("rst_next_resp", 0, 0, 0, 1, 5'b00010);

        // Randomized traffic scored against a transaction-level model.
        do_reset();
        busy = 0; macc = 0; own = 0; last = 1; txn = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            free  = !busy;
            wl    = pick_lsu(bus.ifu_req_valid, bus.lsu_req_valid, last);
            e_ir  = free && bus.ifu_req_valid && !wl;
            e_lr  = free && bus.lsu_req_valid && wl;
            e_mq  = busy && !macc;
            e_rsp = busy && macc && bus.mem_resp_valid;
            check("rnd_ctl", outs(), {e_ir, e_lr, e_mq, e_rsp && !own, e_rsp && own});
            if (e_mq) check("rnd_fields", fields(), txn);
            if (e_rsp)
                check("rnd_data", own ? bus.lsu_resp_data : bus.ifu_resp_data, bus.mem_resp_data);
            if (e_ir || e_lr) begin
                busy = 1; macc = 0; own = e_lr; last = e_lr;
                txn = e_lr ? {bus.lsu_addr, bus.lsu_wen, bus.lsu_wdata, bus.lsu_wmask}
                           : {bus.ifu_addr, 1'b0, 64'b0, 8'b0};
            end else if (busy && !macc && bus.mem_req_ready) macc = 1;
            else if (busy && macc && bus.mem_resp_valid) busy = 0;
            @(posedge clk); #1;
            if (e_ir) bus.ifu_req_valid = 0;
            if (e_lr) bus.lsu_req_valid = 0;
            if (!bus.ifu_req_valid && $urandom_range(2) == 0) begin
                bus.ifu_req_valid = 1;
                bus.ifu_addr = {$urandom, $urandom};
            end
            if (!bus.lsu_req_valid && $urandom_range(2) == 0) begin
                bus.lsu_req_valid = 1;
                bus.lsu_addr  = {$urandom, $urandom};
                bus.lsu_wen   = $urandom_range(1);
                bus.lsu_wdata = {$urandom, $urandom};
                bus.lsu_wmask = 8'($urandom);
            end
            bus.mem_req_ready  = $urandom_range(1);
            bus.mem_resp_valid = ($urandom_range(2) == 0);
            bus.mem_resp_data  = {$urandom, $urandom};
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
